// File: rtl/seg_capture.sv
// Recovers the BCD value shown on each digit of a multiplexed, active-low
// seven-segment bus, with synchronisation, glitch rejection and frame strobes.
module seg_capture #(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NDIG-1:0]   an,
  input  logic [6:0]        segs,
  output logic [4*NDIG-1:0] digits,
  output logic [NDIG-1:0]   digit_valid,
  output logic [NDIG-1:0]   err,
  output logic              update,
  output logic              frame_done
);

  localparam int W  = NDIG + 7;
  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYC);

  logic [W-1:0]    sync1_reg, sync2_reg;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [NDIG-1:0] seen_reg, seen_or, seen_next;
  logic [NDIG-1:0] cap_an, zero_mask, hit, chg;
  logic [6:0]      cap_segs;
  logic            same, cap_time, single, cap_ok;
  logic [3:0]      nib;
  logic            bad;

  // sync1 holds the value that becomes s on this edge, so the count tracks s.
  assign same      = (sync1_reg == sync2_reg);
  assign cap_an    = sync1_reg[W-1:7];
  assign cap_segs  = sync1_reg[6:0];
  assign zero_mask = ~cap_an;
  assign single    = (zero_mask != '0) && ((zero_mask & (zero_mask - NDIG'(1))) == '0);

  always_comb begin
    cnt_next = cnt_reg;
    if (!same) begin
      cnt_next = CW'(1);
    end else if (cnt_reg != CMAX) begin
      cnt_next = cnt_reg + CW'(1);
    end
  end

  // A change that restarts the run at the maximum still counts as reaching it.
  assign cap_time = (cnt_next == CMAX) && (!same || (cnt_reg != CMAX));
  assign cap_ok   = cap_time && single;

  always_comb begin
    bad = 1'b0;
    case (cap_segs)
      7'h40:   nib = 4'h0;
      7'h79:   nib = 4'h1;
      7'h24:   nib = 4'h2;
      7'h30:   nib = 4'h3;
      7'h19:   nib = 4'h4;
      7'h12:   nib = 4'h5;
      7'h02:   nib = 4'h6;
      7'h78:   nib = 4'h7;
      7'h00:   nib = 4'h8;
      7'h18:   nib = 4'h9;
      7'h7F:   nib = 4'hF;
      default: begin
        nib = 4'hE;
        bad = 1'b1;
      end
    endcase
  end

  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_dig
      assign hit[gi] = cap_ok && zero_mask[gi];
      assign chg[gi] = hit[gi] && ((digits[4*gi +: 4] != nib) || (err[gi] != bad));
    end
  endgenerate

  assign seen_or   = seen_reg | hit;
  assign seen_next = (cap_ok && (&seen_or)) ? '0 : seen_or;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= '1;
      sync2_reg <= '1;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= {an, segs};
      sync2_reg <= sync1_reg;
      cnt_reg   <= cnt_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digits      <= '0;
      digit_valid <= '0;
      err         <= '0;
      update      <= 1'b0;
      frame_done  <= 1'b0;
      seen_reg    <= '0;
    end else begin
      for (int i = 0; i < NDIG; i++) begin
        if (hit[i]) begin
          digits[4*i +: 4] <= nib;
          err[i]           <= bad;
          digit_valid[i]   <= 1'b1;
        end
      end
      update     <= |chg;
      frame_done <= cap_ok && (&seen_or);
      seen_reg   <= seen_next;
    end
  end

endmodule

// File: tb/tb_seg_capture.sv
// Randomised and directed bench for seg_capture, checked every cycle against
// a run-length based reference model of the synchronised display bus.
module tb_seg_capture;
  localparam int NDIG   = 4;
  localparam int STABLE = 4;
  localparam logic [6:0] PAT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                      7'h12, 7'h02, 7'h78, 7'h00, 7'h18};

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic [NDIG-1:0]   an = '1;
  logic [6:0]        segs = '1;
  logic [4*NDIG-1:0] digits;
  logic [NDIG-1:0]   digit_valid, err;
  logic              update, frame_done;

  seg_capture #(.NDIG(NDIG), .STABLE_CYC(STABLE)) dut (
    .clk(clk), .reset_n(reset_n), .an(an), .segs(segs),
    .digits(digits), .digit_valid(digit_valid), .err(err),
    .update(update), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int upd_cnt, frm_cnt, first_upd, cyc_no;

  // Model: raw samples per edge, the synced sample sequence and the output image.
  logic [NDIG+6:0]   smp[$];
  logic [NDIG+6:0]   sq[$];
  logic [4*NDIG-1:0] m_dig;
  logic [NDIG-1:0]   m_val, m_err, m_seen;
  logic              m_upd, m_frm;

  task automatic model_reset();
    smp.delete();
    smp.push_back('1);
    sq.delete();
    m_dig = '0; m_val = '0; m_err = '0; m_seen = '0; m_upd = 0; m_frm = 0;
  endtask

  task automatic decode(input logic [6:0] p, output logic [3:0] n, output logic e);
    n = 4'hE;
    e = 1'b1;
    if (p == 7'h7F) begin
      n = 4'hF;
      e = 1'b0;
    end
    for (int k = 0; k < 10; k++) begin
      if (PAT[k] == p) begin
        n = 4'(k);
        e = 1'b0;
      end
    end
  endtask

  task automatic model_step();
    logic [NDIG+6:0] s;
    logic [NDIG-1:0] nz;
    logic [3:0]      n;
    logic            e, brk;
    int              run, idx;
    smp.push_back({an, segs});
    if (smp.size() > 4) void'(smp.pop_front());
    s = smp[smp.size()-2];
    sq.push_back(s);
    if (sq.size() > STABLE + 1) void'(sq.pop_front());
    run = 0;
    brk = 0;
    for (int i = sq.size() - 1; i >= 0; i--) begin
      if (!brk && sq[i] == s) run++;
      else brk = 1;
    end
    m_upd = 0;
    m_frm = 0;
    nz = ~s[NDIG+6:7];
    if (run == STABLE && $countones(nz) == 1) begin
      idx = 0;
      for (int i = 0; i < NDIG; i++) if (nz[i]) idx = i;
      decode(s[6:0], n, e);
      if (m_dig[idx*4 +: 4] != n || m_err[idx] != e) m_upd = 1;
      m_dig[idx*4 +: 4] = n;
      m_err[idx] = e;
      m_val[idx] = 1;
      m_seen[idx] = 1;
      if (&m_seen) begin
        m_frm = 1;
        m_seen = '0;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // One cycle: drive at the falling edge, step the model on the rising edge,
  // compare every output at the next falling edge.
  task automatic cyc(input logic [NDIG-1:0] a, input logic [6:0] sg);
    an = a;
    segs = sg;
    @(posedge clk);
    if (reset_n) model_step();
    @(negedge clk);
    cyc_no++;
    check("cycle_outputs", {digits, digit_valid, err, update, frame_done},
          {m_dig, m_val, m_err, m_upd, m_frm});
    if (update) begin
      upd_cnt++;
      if (first_upd == 0) first_upd = cyc_no;
    end
    if (frame_done) frm_cnt++;
    $display("cyc an=%b segs=%b digits=%h valid=%b err=%b upd=%b frm=%b",
             a, sg, digits, digit_valid, err, update, frame_done);
  endtask

  task automatic clr();
    upd_cnt = 0; frm_cnt = 0; first_upd = 0; cyc_no = 0;
  endtask

  task automatic hold(input logic [NDIG-1:0] a, input logic [6:0] sg, input int n);
    for (int i = 0; i < n; i++) cyc(a, sg);
  endtask

  initial begin
    logic [NDIG-1:0] ra;
    logic [6:0]      rs;
    int              r, len, rcyc;
    clr();
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    check("reset_outputs", {digits, digit_valid, err, update, frame_done}, 32'h0);
    hold('1, '1, 3);
    reset_n = 1'b1;
    hold('1, '1, 4);

    // Single digit capture and latency.
    clr();
    hold(4'b1110, 7'h24, 10);
    check("t2_first_update_cycle", first_upd, 5);
    check("t2_update_pulses", upd_cnt, 1);
    check("t2_digit0", digits[3:0], 4'h2);
    check("t2_valid0", digit_valid[0], 1'b1);

    // Short glitch is rejected.
    clr();
    hold(4'b1110, 7'h30, 2);
    hold(4'b1110, 7'h24, 8);
    check("t3_no_update", upd_cnt, 0);
    check("t3_digit0", digits[3:0], 4'h2);

    // Full scan, then a repeat scan.
    clr();
    for (int d = 0; d < 4; d++) hold(~(4'b1 << d), PAT[d+1], 8);
    check("t4_digits", digits, 16'h4321);
    check("t4_valid", digit_valid, 4'hF);
    check("t4_frame_pulses", frm_cnt, 1);
    clr();
    for (int d = 0; d < 4; d++) hold(~(4'b1 << d), PAT[d+1], 8);
    check("t4_repeat_frame_pulses", frm_cnt, 1);
    check("t4_repeat_no_update", upd_cnt, 0);

    // Unrecognised pattern, then blank.
    clr();
    hold(4'b1101, 7'h55, 8);
    check("t5_digit1_err_val", digits[7:4], 4'hE);
    check("t5_err1", err[1], 1'b1);
    check("t5_update_err", upd_cnt, 1);
    clr();
    hold(4'b1101, 7'h7F, 8);
    check("t5_digit1_blank", digits[7:4], 4'hF);
    check("t5_err1_clear", err[1], 1'b0);
    check("t5_update_blank", upd_cnt, 1);

    // Two enables low: no capture.
    clr();
    hold(4'b1100, 7'h40, 10);
    check("t6_multi_no_update", upd_cnt, 0);
    check("t6_multi_digits", digits, 16'h43F1);

    // Reset mid-hold, then recapture after release.
    hold(4'b1110, 7'h24, 3);
    reset_n = 1'b0;
    model_reset();
    #1;
    check("t6_reset_midhold", {digits, digit_valid, err, update, frame_done}, 32'h0);
    hold(4'b1110, 7'h24, 2);
    reset_n = 1'b1;
    clr();
    hold(4'b1110, 7'h24, 8);
    check("t6_recapture_cycle", first_upd, 5);
    check("t6_recapture_digits", digits, 16'h0002);

    // Random bursts of mixed holds and glitches.
    rcyc = 0;
    while (rcyc < 600) begin
      r = $urandom_range(0, 9);
      if (r < 7) ra = ~(4'b1 << $urandom_range(0, NDIG - 1));
      else if (r == 7) ra = '1;
      else ra = 4'($urandom);
      r = $urandom_range(0, 11);
      if (r < 10) rs = PAT[r];
      else if (r == 10) rs = 7'h7F;
      else rs = 7'($urandom);
      len = $urandom_range(1, 8);
      hold(ra, rs, len);
      rcyc += len;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
